mul32_sig_checker: RTL
======================

// Module: mul32_sig_checker
// PURPOSE
//  Response-side companion to the mul32 LFSR stimulus generator: compacts the pipelined multiplier's 64-bit
//  result stream into a MISR signature over a fixed test window and compares it against a golden value.
//  Sits beside mul32p in the hardware self-test. It discards the first LAT cycles while the pipeline
//  fills, then reports pass/fail.
// PARAMETERS
//  W         64              result/signature width
//  LAT       8               mul32p pipeline latency; cycles discarded after start (0 allowed)
//  N_SAMPLES 1024            results compacted per run (>=2, even)
//  POLY      64'h0000_001B   MISR feedback polynomial (Galois taps)
//  SEED      {W{1'b0}}       signature value loaded on start
//  GOLDEN    {W{1'b0}}       expected final signature
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  start      in   1   begin a run (accepted in IDLE or DONE only)
//  abort      in   1   return to IDLE from any state
//  res        in   W   mul32p result {hi,lo}, one per cycle
//  busy       out  1   high in SKIP or RUN
//  done       out  1   high in DONE
//  pass       out  1   done && signature==GOLDEN
//  fail       out  1   done && signature!=GOLDEN
//  signature  out  W   live MISR register
//  sig_mid    out  W   signature after N_SAMPLES/2 samples (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; busy/done/pass/fail=0; signature=SEED; sig_mid=0; counters=0.
//  FSM: IDLE -start-> SKIP (LAT>0) or RUN (LAT==0); signature<=SEED on that edge.
//   SKIP: res ignored for exactly LAT cycles, then RUN.
//   RUN: each cycle sig <= {sig[W-2:0],1'b0} ^ (sig[W-1] ? POLY : 0) ^ res; after N_SAMPLES updates -> DONE.
//   DONE: signature frozen; pass/fail registered, valid the same cycle done rises; start -> new run.
//  Timing: start high at edge t => res sampled at edges t+1+LAT .. t+LAT+N_SAMPLES; done=1 after edge t+LAT+N_SAMPLES.
//  start while busy: ignored. start and abort same cycle: abort wins, ends in IDLE.
//  abort: -> IDLE next edge; signature retains current value; done/pass/fail cleared.
//  Sample counter width clog2(N_SAMPLES+1); no wrap inside a run. pass and fail never both high.
//  rst asserted mid-run: immediate return to reset values; no partial result reported.
// CONFIGURATION
//  MUL32_SIG_MIDPOINT_EN defined: at the update making sample count N_SAMPLES/2, sig_mid <= new signature;
//   sig_mid holds until next start (cleared to 0 on start) or rst.
//  Not defined: sig_mid tied to 0, no capture register.
// STRUCTURE
//  mul32_pkg.vh: state encodings (IDLE=2'd0, SKIP=2'd1, RUN=2'd2, DONE=2'd3) and default POLY/SEED/GOLDEN.
//  Sub-module misr (params W, POLY; ports clk, rst, load, load_val, en, din, q): the signature register.
//  Top holds FSM, skip/sample counters, compare, midpoint capture.
// TESTING (bench config W=8, LAT=2, N_SAMPLES=4, POLY=8'h1D, SEED=8'h00, GOLDEN=8'h02)
//  Golden run: start; res=FF,FF (skip) then 01,02,03,04 -> signature 01,00,03,02; done=1,pass=1,fail=0.
//  Mismatch: same but 4th sample 05 -> signature 03; fail=1, pass=0.
//  Midpoint (MUL32_SIG_MIDPOINT_EN): golden stream -> sig_mid=8'h00 after 2nd sample; without macro sig_mid=0.
//  Feedback: SEED=8'h80, LAT=0, res=00 x4 -> signature 1D,3A,74,E8.
//  Abort mid-RUN after 2 samples -> IDLE, busy=0, done=0; start with abort same cycle -> stays IDLE.
//  rst pulse during SKIP -> all outputs reset values; restart after rst yields golden pass again.

Source files
------------

// File: rtl/mul32_sig_checker_pkg.sv
//==============================================================================
// Module : mul32_sig_checker_pkg
// Brief  : State encodings and default MISR constants for mul32_sig_checker.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package mul32_sig_checker_pkg;

    localparam logic [1:0]  c_ST_IDLE    = 2'd0;
    localparam logic [1:0]  c_ST_SKIP    = 2'd1;
    localparam logic [1:0]  c_ST_RUN     = 2'd2;
    localparam logic [1:0]  c_ST_DONE    = 2'd3;

    localparam logic [63:0] c_DEF_POLY   = 64'h0000_0000_0000_001B;
    localparam logic [63:0] c_DEF_SEED   = 64'h0;
    localparam logic [63:0] c_DEF_GOLDEN = 64'h0;

endpackage

`default_nettype wire

// File: rtl/mul32_sig_checker_misr.sv
//==============================================================================
// Module : misr
// Brief  : Galois multiple-input signature register; load has priority over en.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module misr #(
    parameter int           W       = 64,
    parameter logic [W-1:0] POLY    = W'(64'h1B),
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;
    logic [W-1:0] w_q_next;

    assign w_q_next = {r_q[W-2:0], 1'b0} ^ (r_q[W-1] ? POLY : '0) ^ din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RST_VAL;
        end else if (load) begin
            r_q <= load_val;
        end else if (en) begin
            r_q <= w_q_next;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/mul32_sig_checker.sv
//==============================================================================
// Module : mul32_sig_checker
// Brief  : Compacts the mul32p result stream into a MISR signature after a
//          pipeline-fill skip window and reports pass/fail against GOLDEN.
//          Optional midpoint capture: define MUL32_SIG_MIDPOINT_EN.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module mul32_sig_checker
    import mul32_sig_checker_pkg::*;
#(
    parameter int           W         = 64,
    parameter int           LAT       = 8,
    parameter int           N_SAMPLES = 1024,
    parameter logic [W-1:0] POLY      = W'(c_DEF_POLY),
    parameter logic [W-1:0] SEED      = W'(c_DEF_SEED),
    parameter logic [W-1:0] GOLDEN    = W'(c_DEF_GOLDEN)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] res,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic         fail,
    output logic [W-1:0] signature,
    output logic [W-1:0] sig_mid
);

    localparam int c_SKIP_W = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam int c_CNT_W  = $clog2(N_SAMPLES + 1);

    localparam logic [c_SKIP_W-1:0] c_SKIP_LAST   = c_SKIP_W'(LAT - 1);
    localparam logic [c_CNT_W-1:0]  c_SAMPLE_LAST = c_CNT_W'(N_SAMPLES - 1);
    localparam logic [c_CNT_W-1:0]  c_MID_LAST    = c_CNT_W'(N_SAMPLES / 2 - 1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic                w_load;
    logic                w_en;
    logic [c_SKIP_W-1:0] r_skip_cnt;
    logic [c_CNT_W-1:0]  r_sample_cnt;
    logic                r_pass;
    logic                r_fail;
    logic [W-1:0]        w_sig;
    logic [W-1:0]        w_sig_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // abort overrides everything, including a simultaneous start
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_en         = 1'b0;
        case (r_state)
            c_ST_IDLE, c_ST_DONE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = (LAT > 0) ? c_ST_SKIP : c_ST_RUN;
                end
            end
            c_ST_SKIP: begin
                if (r_skip_cnt == c_SKIP_LAST) begin
                    w_state_next = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                w_en = 1'b1;
                if (r_sample_cnt == c_SAMPLE_LAST) begin
                    w_state_next = c_ST_DONE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
        if (abort) begin
            w_state_next = c_ST_IDLE;
            w_load       = 1'b0;
            w_en         = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skip_cnt   <= '0;
            r_sample_cnt <= '0;
        end else if (w_load) begin
            r_skip_cnt   <= '0;
            r_sample_cnt <= '0;
        end else begin
            if (r_state == c_ST_SKIP && !abort) begin
                r_skip_cnt <= r_skip_cnt + 1'b1;
            end
            if (w_en) begin
                r_sample_cnt <= r_sample_cnt + 1'b1;
            end
        end
    end

    misr #(
        .W       (W),
        .POLY    (POLY),
        .RST_VAL (SEED)
    ) u_misr (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (SEED),
        .en       (w_en),
        .din      (res),
        .q        (w_sig)
    );

    // Same step as the MISR, so the verdict is ready on the edge done rises
    assign w_sig_next = {w_sig[W-2:0], 1'b0} ^ (w_sig[W-1] ? POLY : '0) ^ res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end else if (abort || w_load) begin
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end else if (w_en && r_sample_cnt == c_SAMPLE_LAST) begin
            r_pass <= (w_sig_next == GOLDEN);
            r_fail <= (w_sig_next != GOLDEN);
        end
    end

`ifdef MUL32_SIG_MIDPOINT_EN
    logic [W-1:0] r_sig_mid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig_mid <= '0;
        end else if (w_load) begin
            r_sig_mid <= '0;
        end else if (w_en && r_sample_cnt == c_MID_LAST) begin
            r_sig_mid <= w_sig_next;
        end
    end

    assign sig_mid = r_sig_mid;
`else
    assign sig_mid = '0;
`endif

    assign busy      = (r_state == c_ST_SKIP) || (r_state == c_ST_RUN);
    assign done      = (r_state == c_ST_DONE);
    assign pass      = r_pass;
    assign fail      = r_fail;
    assign signature = w_sig;

endmodule

`default_nettype wire
